// File: rtl/reg_bank.sv
// reg_bank: MIPS 32x32 register file, $0 reads zero, $sp loads SP_RESET on reset.
// Optional same-cycle write-through to the read ports when REG_BANK_BYPASS_EN is defined.
module reg_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    logic [DATA_W-1:0] r_regs [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++)
                r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
        end else if (RegWrite && WriteReg != '0) begin
            r_regs[WriteReg] <= WriteData;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic w_wr_en;
    assign w_wr_en = RegWrite && !reset && WriteReg != '0;
    always_comb begin
        ReadData1 = (ReadReg1 == '0) ? '0 : (w_wr_en && ReadReg1 == WriteReg) ? WriteData : r_regs[ReadReg1];
        ReadData2 = (ReadReg2 == '0) ? '0 : (w_wr_en && ReadReg2 == WriteReg) ? WriteData : r_regs[ReadReg2];
    end
`else
    always_comb begin
        ReadData1 = (ReadReg1 == '0) ? '0 : r_regs[ReadReg1];
        ReadData2 = (ReadReg2 == '0) ? '0 : r_regs[ReadReg2];
    end
`endif
endmodule
